// File: rtl/fmul_issue.sv
// Issue/collect stage in front of the FPU multiplier: registers operands, tracks each op
// through the fixed multiplier latency and buffers {result, tag} in an in-order FIFO.
module fmul_issue #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_x1,
    input  logic [31:0]     in_x2,
    input  logic [TAGW-1:0] in_tag,
    output logic [31:0]     mul_x1,
    output logic [31:0]     mul_x2,
    input  logic [31:0]     mul_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_y,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]     r_mul_x1;
    logic [31:0]     r_mul_x2;
    logic [LAT-1:0]  r_vld;
    logic [TAGW-1:0] r_ptag [LAT];
    logic [31:0]     r_fy   [DEPTH];
    logic [TAGW-1:0] r_ftag [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_fcnt;
    logic [CW-1:0]   r_cnt;

    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_clear;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check covers in-flight ops too, so a capture always finds a free FIFO slot.
    assign in_ready  = rstn & ~flush & (r_cnt < CW'(DEPTH));
    assign w_accept  = in_valid & in_ready;
    assign w_push    = r_vld[LAT-1];
    assign out_valid = (r_fcnt != '0);
    assign w_pop     = out_valid & out_ready;
    assign w_clear   = ~rstn | flush;

    assign mul_x1  = r_mul_x1;
    assign mul_x2  = r_mul_x2;
    assign out_y   = out_valid ? r_fy[r_rptr]   : '0;
    assign out_tag = out_valid ? r_ftag[r_rptr] : '0;
    assign busy    = (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mul_x1 <= '0;
            r_mul_x2 <= '0;
        end else if (w_accept) begin
            r_mul_x1 <= in_x1;
            r_mul_x2 <= in_x2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i < LAT; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_ptag[0] <= in_tag;
        for (int i = 1; i < LAT; i++) r_ptag[i] <= r_ptag[i-1];
    end

    // mul_y is only looked at on the edge where the tracked op leaves the valid chain.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fy[r_wptr]   <= mul_y;
            r_ftag[r_wptr] <= r_ptag[LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_next(r_wptr);
            if (w_pop)  r_rptr <= ptr_next(r_rptr);
            r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
            r_cnt  <= r_cnt + CW'(w_accept) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_fmul_issue.sv
// Directed bench for fmul_issue with a pipelined mock multiplier and an in-order scoreboard.
module tb_fmul_issue;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TAGW  = 5;

    logic            clk = 1'b0;
    logic            rstn, flush, in_valid, in_ready;
    logic [31:0]     in_x1, in_x2, mul_x1, mul_x2, mul_y, out_y;
    logic [TAGW-1:0] in_tag, out_tag;
    logic            out_valid, out_ready, busy;

    logic [31:0]        mock_q;
    logic [TAGW+31:0]   sb [$];
    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;

    fmul_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
        .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mock(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] opx1(input int t);
        return 32'h3F80_0000 + (32'(t) << 12);
    endfunction

    function automatic logic [31:0] opx2(input int t);
        return 32'h4100_0000 ^ (32'(t) << 4);
    endfunction

    // Mock multiplier: LAT-1 register stages after the operand register.
    always @(posedge clk) mock_q <= mock(mul_x1, mul_x2);
    assign mul_y = mock_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int t);
        in_x1  = opx1(t);
        in_x2  = opx2(t);
        in_tag = TAGW'(t);
    endtask

    task automatic drain(input int max);
        for (int k = 0; k < max && (sb.size() != 0 || busy); k++) tick();
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_sb", sb.size(), 32'd0);
    endtask

    // Sampled mid-cycle: inputs are stable and reflect what the next edge will see.
    always @(negedge clk) begin
        logic [TAGW+31:0] e;
        if (!rstn || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_y", out_y, e[31:0]);
                    chk("out_tag", {{(32-TAGW){1'b0}}, out_tag}, {{(32-TAGW){1'b0}}, e[TAGW+31:32]});
                end
            end
            if (in_valid && in_ready) sb.push_back({in_tag, mock(in_x1, in_x2)});
        end
    end

    initial begin
        int acc;
        int p0;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_x1 = '0; in_x2 = '0; in_tag = '0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mul_x1", mul_x1, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rstn = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // single op
        in_valid = 1'b1; in_x1 = 32'h3FC0_0000; in_x2 = 32'h4000_0000; in_tag = 5'd3;
        out_ready = 1'b1;
        tick();
        chk("single_mul_x1", mul_x1, 32'h3FC0_0000);
        chk("single_mul_x2", mul_x2, 32'h4000_0000);
        in_valid = 1'b0;
        chk("single_ov_e0", {31'd0, out_valid}, 32'd0);
        tick();
        chk("single_ov_e1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("single_ov_e2", {31'd0, out_valid}, 32'd1);
        chk("single_y", out_y, 32'h4040_0000);
        chk("single_tag", {27'd0, out_tag}, 32'd3);
        tick();
        chk("single_ov_e3", {31'd0, out_valid}, 32'd0);
        chk("single_busy", {31'd0, busy}, 32'd0);

        // streaming
        for (int i = 0; i < 8; i++) begin
            set_op(i);
            in_valid = 1'b1;
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            if (i >= 2) begin
                chk("stream_ov", {31'd0, out_valid}, 32'd1);
                chk("stream_tag", {27'd0, out_tag}, 32'(i - 2));
            end
        end
        in_valid = 1'b0;
        drain(20);

        // backpressure
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            set_op(i);
            in_valid = 1'b1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepts", acc, 32'd4);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_y", out_y, mock(opx1(0), opx2(0)));
        chk("bp_hold_tag", {27'd0, out_tag}, 32'd0);
        tick();
        tick();
        chk("bp_hold_y2", out_y, mock(opx1(0), opx2(0)));
        chk("bp_hold_tag2", {27'd0, out_tag}, 32'd0);
        chk("bp_in_ready2", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready_reassert", {31'd0, in_ready}, 32'd1);
        drain(20);

        // full FIFO then simultaneous push/pop
        out_ready = 1'b0;
        p0 = n_pop;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            set_op(8 + i);
            in_valid = 1'b1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < LAT + 1; i++) tick();
        chk("full_ov", {31'd0, out_valid}, 32'd1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_op(12 + i);
            in_valid = 1'b1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        drain(20);
        chk("full_pop_count", n_pop - p0, acc);

        // flush with 1 buffered and 2 in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(20 + i);
            in_valid = 1'b1;
            tick();
        end
        chk("pre_flush_ov", {31'd0, out_valid}, 32'd1);
        set_op(23);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_ov", {31'd0, out_valid}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_mul_x1", mul_x1, opx1(22));
        out_ready = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk("flush_no_stale", {31'd0, out_valid}, 32'd0);
        end
        set_op(24);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(20);

        // reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(25 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("mrst_mul_x1", mul_x1, 32'd0);
        chk("mrst_mul_x2", mul_x2, 32'd0);
        chk("mrst_ov", {31'd0, out_valid}, 32'd0);
        chk("mrst_y", out_y, 32'd0);
        chk("mrst_tag", {27'd0, out_tag}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            chk("mrst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        set_op(30);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
